sine_stim_sequencer: RTL and testbench
======================================

// Module: sine_stim_sequencer
// PURPOSE
//  Address sequencer for the dual/triple-read sine sample ROM feeding the L=3 parallel FIR.
//  Emits one ROM base address per block; the ROM returns samples base, base+1, base+2 combinationally.
//  Handshakes each 3-sample block to the FIR input with valid/ready and counts blocks.
//  Runs a programmed number of blocks or free-runs until stopped, wrapping inside the legal ROM range.
// PARAMETERS
//  ADDR_WIDTH  9   ROM address width; DEPTH = 2**ADDR_WIDTH
//  STRIDE      3   samples per block (parallelism L); address increment per accepted block
//  CNT_WIDTH   16  width of num_blocks / block_cnt
// PORTS
//  clk         in   1           clock, all logic rising-edge
//  rst         in   1           synchronous, active-high reset
//  start       in   1           pulse: begin a run (accepted only in IDLE)
//  stop        in   1           level/pulse: end a run early (RUN only)
//  num_blocks  in   CNT_WIDTH   blocks per run, latched on accepted start; 0 = free-run
//  out_ready   in   1           FIR input can accept the current block
//  r_addr      out  ADDR_WIDTH  ROM base address (drives ROM r_addr)
//  out_valid   out  1           r_addr is a live block; ROM data valid same cycle
//  block_cnt   out  CNT_WIDTH   blocks accepted in current/last run
//  busy        out  1           high in RUN and DONE
//  done        out  1           one-cycle pulse at end of run
// BEHAVIOUR
//  - Reset: state=IDLE, r_addr=0, out_valid=0, block_cnt=0, busy=0, done=0; reset mid-run aborts
//    immediately (no done pulse), latched num_blocks cleared.
//  - MAX_BASE = DEPTH-STRIDE (509 at defaults): highest base with base+STRIDE-1 in range.
//  - States: IDLE -> RUN on start; RUN -> DONE on last accepted block or stop; DONE -> IDLE always (1 cycle).
//  - IDLE: out_valid=0; r_addr holds; start=1 -> next cycle RUN, r_addr=start base, block_cnt=0,
//    num_blocks latched, out_valid=1. stop ignored in IDLE.
//  - RUN: out_valid=1. Transfer = out_valid & out_ready. On transfer: block_cnt+1 (wraps at 2**CNT_WIDTH);
//    r_addr <= r_addr+STRIDE, or 0 if r_addr+STRIDE > MAX_BASE (defaults: 507 -> 0). No transfer: all hold.
//  - Last block: transfer while latched num_blocks!=0 and block_cnt+1==num_blocks -> DONE.
//  - stop in RUN -> DONE next cycle; a transfer in the same cycle still counts and advances r_addr.
//  - DONE: out_valid=0, done=1, busy=1, block_cnt holds final value until next start.
//  - start while RUN/DONE ignored; start and stop same cycle in IDLE: start wins.
//  - Latency: start to first out_valid = 1 cycle; ROM path combinational, zero added latency.
//  - Width arithmetic on r_addr+STRIDE done at ADDR_WIDTH+1 bits so wrap check never overflows.
// CONFIGURATION
//  SINE_SEQ_PHASE_EN defined: extra input start_addr[ADDR_WIDTH-1:0]; run base = start_addr,
//    replaced by 0 if start_addr > MAX_BASE; latched on accepted start.
//  Undefined: no start_addr port; every run begins at base 0.
// TESTING
//  1 rst, start, num_blocks=4, out_ready=1 -> r_addr 0,3,6,9 with out_valid; done pulse; block_cnt=4.
//  2 num_blocks=0, out_ready=1, 170 cycles -> r_addr reaches 507 then 0; never exceeds 509.
//  3 num_blocks=3, out_ready toggles 1,0,0,1,1 -> r_addr holds on ready=0; 3 transfers then done.
//  4 free-run, stop asserted with out_ready=1 at r_addr=12 -> transfer counted, DONE, block_cnt=5.
//  5 rst asserted mid-run at r_addr=30 -> next cycle IDLE, r_addr=0, out_valid=0, no done pulse.
//  6 SINE_SEQ_PHASE_EN: start_addr=100 -> first r_addr=100; start_addr=511 -> first r_addr=0.

Source files
------------

// File: rtl/sine_stim_sequencer.sv
// Base-address sequencer for the triple-read sine ROM that feeds the L=3 parallel FIR.
// Optional feature macro: SINE_SEQ_PHASE_EN adds a start_addr input that sets the run's phase.
module sine_stim_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int STRIDE     = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  num_blocks,
  input  logic                  out_ready,
`ifdef SINE_SEQ_PHASE_EN
  input  logic [ADDR_WIDTH-1:0] start_addr,
`endif
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  block_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Sums are formed one bit wider than the address so the wrap compare cannot overflow.
  localparam logic [ADDR_WIDTH:0] MAX_BASE = (ADDR_WIDTH + 1)'(DEPTH - STRIDE);
  localparam logic [ADDR_WIDTH:0] STRIDE_W = (ADDR_WIDTH + 1)'(STRIDE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0]   nblk_reg, nblk_next;
  logic [ADDR_WIDTH:0]    addr_sum;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [ADDR_WIDTH-1:0]  start_base;
  logic                   xfer;

`ifdef SINE_SEQ_PHASE_EN
  // Out-of-range phases would read past the ROM end, so they fall back to base 0.
  assign start_base = ({1'b0, start_addr} > MAX_BASE) ? '0 : start_addr;
`else
  assign start_base = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      nblk_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      nblk_reg  <= nblk_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    nblk_next  = nblk_reg;
    xfer       = (state_reg == RUN) && out_ready;
    addr_sum   = {1'b0, addr_reg} + STRIDE_W;
    cnt_inc    = cnt_reg + 1'b1;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          addr_next  = start_base;
          cnt_next   = '0;
          nblk_next  = num_blocks;
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_next  = cnt_inc;
          addr_next = (addr_sum > MAX_BASE) ? '0 : addr_sum[ADDR_WIDTH-1:0];
          if ((nblk_reg != '0) && (cnt_inc == nblk_reg)) begin
            state_next = DONE;
          end
        end
        // A stop still lets a same-cycle transfer count and advance.
        if (stop) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign r_addr    = addr_reg;
  assign out_valid = (state_reg == RUN);
  assign block_cnt = cnt_reg;
  assign busy      = (state_reg == RUN) || (state_reg == DONE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_sine_stim_sequencer.sv
// Scoreboard bench for sine_stim_sequencer: expected base addresses are queued at stimulus time
// and popped whenever the DUT presents a transfer.
module tb_sine_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] num_blocks = '0;
  logic        out_ready = 1'b0;
`ifdef SINE_SEQ_PHASE_EN
  logic [8:0]  start_addr = '0;
`endif
  logic [8:0]  r_addr;
  logic        out_valid;
  logic [15:0] block_cnt;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  e;

  always #5 clk = ~clk;

  sine_stim_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .num_blocks (num_blocks),
    .out_ready  (out_ready),
`ifdef SINE_SEQ_PHASE_EN
    .start_addr (start_addr),
`endif
    .r_addr     (r_addr),
    .out_valid  (out_valid),
    .block_cnt  (block_cnt),
    .busy       (busy),
    .done       (done)
  );

  // Stimulus only: one-cycle start pulse, returns at the negedge after it is sampled.
  task automatic pulse_start(input logic [15:0] nb, input logic with_stop);
    @(negedge clk);
    start      = 1'b1;
    stop       = with_stop;
    num_blocks = nb;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({r_addr, out_valid, block_cnt, busy, done} !== {9'd0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got addr=%0d valid=%b cnt=%0d busy=%b done=%b, want all zero",
               r_addr, out_valid, block_cnt, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_run;
    bit done_seen = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(9'(i * 3));
    out_ready = 1'b1;
    pulse_start(16'd4, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency: out_valid=%b, want 1", out_valid);
    end
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL basic_extra_xfer: addr=%0d with nothing expected", r_addr);
        end else begin
          e = exp_q.pop_front();
          if (r_addr !== e) begin
            n_err++;
            $display("FAIL basic_addr: got %0d want %0d", r_addr, e);
          end
        end
      end
      if (done) done_seen = 1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!done_seen || block_cnt !== 16'd4 || exp_q.size() != 0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done: seen=%0d cnt=%0d left=%0d busy=%b, want 1/4/0/1",
               done_seen, block_cnt, exp_q.size(), busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || block_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL basic_after_done: done=%b busy=%b cnt=%0d, want 0/0/4", done, busy, block_cnt);
    end
  endtask

  task automatic test_free_run_wrap;
    int xfers = 0;
    int max_addr = 0;
    exp_q.delete();
    for (int i = 0; i < 170; i++) exp_q.push_back(9'(i * 3));
    exp_q.push_back(9'd0);
    out_ready = 1'b1;
    pulse_start(16'd0, 1'b0);
    for (int c = 0; c < 250 && xfers < 171; c++) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (r_addr !== e) begin
          n_err++;
          $display("FAIL wrap_addr: xfer %0d got %0d want %0d", xfers, r_addr, e);
        end
        if (int'(r_addr) > max_addr) max_addr = int'(r_addr);
        xfers++;
      end
      if (xfers < 171) @(negedge clk);
    end
    n_cmp++;
    if (xfers != 171 || max_addr != 507) begin
      n_err++;
      $display("FAIL wrap_range: xfers=%0d max=%0d, want 171/507", xfers, max_addr);
    end
    @(negedge clk);
    out_ready = 1'b0;
    stop      = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || block_cnt !== 16'd171 || r_addr !== 9'd3) begin
      n_err++;
      $display("FAIL wrap_stop: done=%b cnt=%0d addr=%0d, want 1/171/3", done, block_cnt, r_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(9'(i * 3));
    out_ready = 1'b0;
    pulse_start(16'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      out_ready = pat[k];
      n_cmp++;
      if (!out_valid || exp_q.size() == 0) begin
        n_err++;
        $display("FAIL bp_valid: cycle %0d valid=%b left=%0d, want valid with data", k, out_valid,
                 exp_q.size());
      end else if (out_ready) begin
        e = exp_q.pop_front();
        if (r_addr !== e) begin
          n_err++;
          $display("FAIL bp_addr: got %0d want %0d", r_addr, e);
        end
      end else if (r_addr !== exp_q[0]) begin
        n_err++;
        $display("FAIL bp_hold: got %0d want %0d", r_addr, exp_q[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || block_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL bp_done: done=%b valid=%b cnt=%0d, want 1/0/3", done, out_valid, block_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_stop_with_transfer;
    int xfers = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(9'(i * 3));
    out_ready = 1'b1;
    pulse_start(16'd0, 1'b0);
    for (int c = 0; c < 20 && xfers < 5; c++) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (r_addr !== e) begin
          n_err++;
          $display("FAIL stop_addr: got %0d want %0d", r_addr, e);
        end
        xfers++;
      end
      if (xfers == 5) stop = 1'b1;
      @(negedge clk);
    end
    stop      = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || block_cnt !== 16'd5 || r_addr !== 9'd15 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_done: done=%b cnt=%0d addr=%0d valid=%b, want 1/5/15/0",
               done, block_cnt, r_addr, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int xfers = 0;
    bit done_hit = 0;
    out_ready = 1'b1;
    pulse_start(16'd0, 1'b0);
    for (int c = 0; c < 20 && xfers < 10; c++) begin
      if (out_valid && out_ready) xfers++;
      @(negedge clk);
    end
    n_cmp++;
    if (r_addr !== 9'd30 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: addr=%0d valid=%b, want 30/1", r_addr, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (r_addr !== 9'd0 || out_valid !== 1'b0 || busy !== 1'b0 || block_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_state: addr=%0d valid=%b busy=%b cnt=%0d, want 0/0/0/0",
               r_addr, out_valid, busy, block_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      if (done) done_hit = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (done_hit) begin
      n_err++;
      $display("FAIL midrst_done: done pulse seen=1, want 0");
    end
  endtask

  task automatic test_start_stop_same;
    bit done_seen = 0;
    exp_q.delete();
    exp_q.push_back(9'd0);
    exp_q.push_back(9'd3);
    out_ready = 1'b0;
    pulse_start(16'd2, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || r_addr !== 9'd0) begin
      n_err++;
      $display("FAIL startstop_win: valid=%b addr=%0d, want 1/0", out_valid, r_addr);
    end
    start = 1'b1;  // start during RUN must not restart the run
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !done_seen; c++) begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (r_addr !== e) begin
          n_err++;
          $display("FAIL startstop_addr: got %0d want %0d", r_addr, e);
        end
      end
      if (done) done_seen = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (!done_seen || block_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL startstop_done: seen=%0d cnt=%0d, want 1/2", done_seen, block_cnt);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef SINE_SEQ_PHASE_EN
  task automatic test_phase;
    out_ready  = 1'b0;
    start_addr = 9'd100;
    pulse_start(16'd0, 1'b0);
    n_cmp++;
    if (r_addr !== 9'd100) begin
      n_err++;
      $display("FAIL phase_100: got %0d want 100", r_addr);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    start_addr = 9'd511;
    pulse_start(16'd0, 1'b0);
    n_cmp++;
    if (r_addr !== 9'd0) begin
      n_err++;
      $display("FAIL phase_511: got %0d want 0", r_addr);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_free_run_wrap();
    test_backpressure();
    test_stop_with_transfer();
    test_reset_mid_run();
    test_start_stop_same();
`ifdef SINE_SEQ_PHASE_EN
    test_phase();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
